// File: rtl/fft_iter_r2.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, one butterfly per clock, natural-order unload.
// Define FFT_STAGE_SCALE_EN to halve every butterfly output (overall gain 1/N instead of N).
module fft_iter_r2 #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 8,
    parameter int TW_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_real,
    output logic signed [DATA_WIDTH-1:0] out_imag,
    output logic [$clog2(N)-1:0]         out_index,
    output logic                         out_last,
    output logic                         busy
);
    localparam int  L         = $clog2(N);
    localparam int  SW        = $clog2(L);
    localparam int  FRAC_BITS = TW_WIDTH - 2;
    localparam int  PW        = DATA_WIDTH + TW_WIDTH + 1;
    localparam int  EW        = DATA_WIDTH + 2;
    localparam real PI        = 3.14159265358979323846;

    localparam logic signed [PW-1:0] RND     = PW'(2 ** (FRAC_BITS - 1));
    localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = EW'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

    function automatic logic signed [TW_WIDTH-1:0] tw_round(input real x);
        real r;
        r = x * (2.0 ** FRAC_BITS);
        if (r >= 0.0) return TW_WIDTH'($rtoi(r + 0.5));
        else          return TW_WIDTH'(-$rtoi(0.5 - r));
    endfunction

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++) r[i] = v[L-1-i];
        return r;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SAT_MAX)      return DATA_WIDTH'(SAT_MAX);
        else if (v < SAT_MIN) return DATA_WIDTH'(SAT_MIN);
        else                  return DATA_WIDTH'(v);
    endfunction

    logic signed [TW_WIDTH-1:0] tw_re [N/2];
    logic signed [TW_WIDTH-1:0] tw_im [N/2];

    for (genvar k = 0; k < N/2; k++) begin : g_tw
        localparam logic signed [TW_WIDTH-1:0] TW_RE = tw_round($cos(2.0 * PI * k / N));
        localparam logic signed [TW_WIDTH-1:0] TW_IM = tw_round(-$sin(2.0 * PI * k / N));
        assign tw_re[k] = TW_RE;
        assign tw_im[k] = TW_IM;
    end

    state_t                       state_q, state_d;
    logic [L-1:0]                 cnt_q, cnt_d;
    logic [SW-1:0]                stage_q, stage_d;
    logic [L-2:0]                 bfly_q, bfly_d;
    logic [L-1:0]                 idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] mem_re_q [N];
    logic signed [DATA_WIDTH-1:0] mem_im_q [N];
    logic signed [DATA_WIDTH-1:0] mem_re_d [N];
    logic signed [DATA_WIDTH-1:0] mem_im_d [N];

    logic [L-1:0]                 b_ext, half, pos, top, bot;
    logic [L-2:0]                 tw_idx;
    logic signed [TW_WIDTH-1:0]   w_re, w_im;
    logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic signed [PW-1:0]         br_x, bi_x, wr_x, wi_x, p_re, p_im;
    logic signed [EW-1:0]         t_re, t_im, s_top_re, s_top_im, s_bot_re, s_bot_im;

    // Butterfly addressing and arithmetic for the current (stage, butterfly) pair.
    always_comb begin
        b_ext  = L'(bfly_q);
        half   = L'(1) << stage_q;
        pos    = b_ext & (half - L'(1));
        top    = (((b_ext >> stage_q) << stage_q) << 1) + pos;
        bot    = top + half;
        tw_idx = pos[L-2:0] << (SW'(L - 1) - stage_q);
        w_re   = tw_re[tw_idx];
        w_im   = tw_im[tw_idx];
        a_re   = mem_re_q[top];
        a_im   = mem_im_q[top];
        b_re   = mem_re_q[bot];
        b_im   = mem_im_q[bot];
        br_x   = PW'(b_re);
        bi_x   = PW'(b_im);
        wr_x   = PW'(w_re);
        wi_x   = PW'(w_im);
        p_re   = br_x * wr_x - bi_x * wi_x;
        p_im   = br_x * wi_x + bi_x * wr_x;
        t_re   = EW'((p_re + RND) >>> FRAC_BITS);
        t_im   = EW'((p_im + RND) >>> FRAC_BITS);
`ifdef FFT_STAGE_SCALE_EN
        s_top_re = (EW'(a_re) + t_re) >>> 1;
        s_top_im = (EW'(a_im) + t_im) >>> 1;
        s_bot_re = (EW'(a_re) - t_re) >>> 1;
        s_bot_im = (EW'(a_im) - t_im) >>> 1;
`else
        s_top_re = EW'(a_re) + t_re;
        s_top_im = EW'(a_im) + t_im;
        s_bot_re = EW'(a_re) - t_re;
        s_bot_im = EW'(a_im) - t_im;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        idx_d     = idx_q;
        mem_re_d  = mem_re_q;
        mem_im_d  = mem_im_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_real  = '0;
        out_imag  = '0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_re_d[bitrev(cnt_q)] = in_real;
                    mem_im_d[bitrev(cnt_q)] = in_imag;
                    cnt_d = cnt_q + L'(1);
                    if (cnt_q == L'(N - 1)) state_d = S_CALC;
                end
            end
            S_CALC: begin
                busy          = 1'b1;
                mem_re_d[top] = sat(s_top_re);
                mem_im_d[top] = sat(s_top_im);
                mem_re_d[bot] = sat(s_bot_re);
                mem_im_d[bot] = sat(s_bot_im);
                if (bfly_q == (L-1)'(N/2 - 1)) begin
                    bfly_d = '0;
                    if (stage_q == SW'(L - 1)) begin
                        stage_d = '0;
                        state_d = S_OUT;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    bfly_d = bfly_q + (L-1)'(1);
                end
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_real  = mem_re_q[idx_q];
                out_imag  = mem_im_q[idx_q];
                if (out_ready) begin
                    idx_d = idx_q + L'(1);
                    if (idx_q == L'(N - 1)) state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign out_index = idx_q;
    assign out_last  = (state_q == S_OUT) && (idx_q == L'(N - 1));

    // The sample array is not reset; a frame is always fully loaded before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            bfly_q   <= bfly_d;
            idx_q    <= idx_d;
            mem_re_q <= mem_re_d;
            mem_im_q <= mem_im_d;
        end
    end
endmodule

// File: doc/fft_iter_r2.md
Name: fft_iter_r2

Overview:
- Parametrised, resource-shared radix-2 DIT FFT; successor to the fixed 8-point, fully combinational FFT.
- Accepts one complex sample per handshake and stores it at its bit-reversed address in an internal N-entry register array.
- Computes log2(N) stages in place with one butterfly per clock, then streams bins X[0..N-1] out in natural order with valid/ready.
- Sits between the sample source and spectral post-processing blocks in the DSP datapath.

Parameters:
- DATA_WIDTH, 16, signed width of each real/imag sample and bin.
- N, 8, FFT points; power of two, 4..1024.
- TW_WIDTH, 16, signed twiddle width; FRAC_BITS = TW_WIDTH-2, so 1.0 is exactly representable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_real  in  DATA_WIDTH  signed sample, real part.
- in_imag  in  DATA_WIDTH  signed sample, imaginary part.
- out_valid  out  1  bin valid.
- out_ready  in  1  downstream accepts bin.
- out_real  out  DATA_WIDTH  signed bin, real part.
- out_imag  out  DATA_WIDTH  signed bin, imaginary part.
- out_index  out  $clog2(N)  bin number of the current output.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in S_CALC or S_OUT.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=S_LOAD; all counters 0; out_valid=0, out_last=0, out_index=0, busy=0; out_real/out_imag=0.
  - Array contents after reset are don't-care.
  - Reset mid-frame (any state) discards the frame; in_ready is 1 on the cycle after rst deasserts.
- FSM S_LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write sample n (n = load count) to addr bitrev(n), then increment n.
  - Handshake with n=N-1 -> S_CALC, n=0.
- FSM S_CALC:
  - in_ready=0, busy=1.
  - Counters: stage s in 0..L-1 (L=log2N); butterfly b in 0..N/2-1.
  - half=2^s; pos=b&(half-1); top=((b>>s)<<(s+1))+pos; bot=top+half; twiddle k=pos<<(L-1-s).
  - Each cycle: read array[top], array[bot] combinationally; compute butterfly; write both results back at the clock edge.
  - b wraps to 0 and s increments. Last butterfly of stage L-1 -> S_OUT.
  - Takes exactly (N/2)*L cycles (12 for N=8).
- FSM S_OUT:
  - out_valid=1; out_real/out_imag=array[out_index].
  - Outputs hold stable while out_ready=0.
  - On handshake, out_index increments.
  - Handshake with out_index=N-1 (out_last=1) -> S_LOAD, out_index=0.
  - in_ready stays 0 until then; no load/unload overlap.
- Latency: out_valid rises (N/2)*L+1 cycles after the cycle of the last input handshake.
- Twiddles: W[k] = round(cos(2πk/N)*2^FRAC_BITS) - j*round(sin(2πk/N)*2^FRAC_BITS), k=0..N/2-1.
  - Built as an elaboration-time constant table.
- Butterfly arithmetic:
  - t = W*B computed at full precision.
  - Each product component is rounded half-up: add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
  - A' = A+t, B' = A-t, computed at DATA_WIDTH+2 bits and saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Throughput: one frame per N + (N/2)*L + N cycles at full out_ready.

Optional Feature:
- Macro: FFT_STAGE_SCALE_EN.
- Defined: every butterfly output is arithmetic-shifted right by 1 before saturation (rounding toward -inf); overall gain 1/N, and saturation cannot occur for in-range inputs.
- Undefined: no scaling; gain N, with saturation as above.

Test Plan:
- N=8, scale off; x[0]=1000, others 0 -> all 8 bins real=1000, imag=0; out_last only on index 7.
- N=8, scale off; x[n]=100 for all n -> X[0]=800, X[1..7]=0.
- N=8, scale off; x[n]=round(1000*cos(2πn/8)) -> X[1]=X[7]=4000±2 real, all other bins |.|≤2.
- N=8, scale off; all samples 32767+j0 -> X[0]=32767 (saturated), X[1..7]=0.
- N=8, FFT_STAGE_SCALE_EN defined; impulse x[0]=1000 -> all bins 125.
  - Same run: out_ready toggled 1-0-0-1 pattern -> out_real/out_index stable while stalled; no bin lost or duplicated.
- rst pulsed in S_CALC after 5 butterflies:
  - Next cycle: in_ready=1, busy=0, out_valid=0.
  - A following full impulse frame yields correct bins at the nominal 13-cycle latency.
